mp_add_seq: RTL and testbench
=============================

Name: mp_add_seq

Overview:
- Sequential multi-precision add controller wrapped around the 32-bit combinational adder stage.
- Accepts operand pairs as a stream of 32-bit limbs, least-significant limb first, with a valid/ready handshake.
- Drives each limb pair onto the adder inputs and consumes the adder's 33-bit result.
- Folds in the inter-limb carry with an internal incrementer and emits a registered stream of result limbs plus the final carry-out. Used for 64- to 256-bit field and key arithmetic in the crypto datapath.

Parameters:
- LIMB_W, 32: limb width. Fixed to the adder width; any other value is an elaboration error.
- MAX_LIMBS, 8: maximum limbs per operand. Sets the limb counter width, $clog2(MAX_LIMBS)+1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  limb pair valid.
- in_ready  out  1  block can accept a limb pair.
- in_a  in  LIMB_W  operand A limb.
- in_b  in  LIMB_W  operand B limb.
- in_last  in  1  most-significant limb of this operand pair.
- add_a  out  LIMB_W  to adder operand A; combinational copy of in_a.
- add_b  out  LIMB_W  to adder operand B; copy of in_b, or ~in_b in subtract mode.
- add_s  in  LIMB_W+1  from adder: {cout, sum[LIMB_W-1:0]}.
- out_valid  out  1  result limb valid.
- out_ready  in  1  downstream accepts the result limb.
- out_sum  out  LIMB_W  result limb.
- out_last  out  1  final limb of this result.
- out_carry  out  1  final carry-out; meaningful only when out_last=1, else 0.
- err_len  out  1  sticky: operand exceeded MAX_LIMBS.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_sum=0, out_last=0, out_carry=0, err_len=0, carry=0, limb_cnt=0, state=IDLE.
- in_ready = !out_valid || out_ready. One-entry output register; full throughput of 1 limb/cycle.
- Accept occurs when in_valid && in_ready. Result appears on out_* the next cycle (latency 1).
- Per accepted limb, with c = (state==IDLE) ? cin0 : carry, and cin0=0 for add:
  - out_sum <= add_s[31:0] + c, wrapping mod 2^32.
  - carry_next = add_s[32] | (c & (add_s[31:0]==32'hFFFF_FFFF)). Both terms are never 1 at once.
- States:
  - IDLE: no operand in flight. An accept moves to BUSY, or stays in IDLE if in_last.
  - BUSY: each accept increments limb_cnt. An accept with in_last returns to IDLE.
- On the last limb:
  - out_last<=1 and out_carry<=carry_next.
  - carry resets to cin0 and limb_cnt to 0.
  - Otherwise carry<=carry_next and out_last<=0.
- Length overflow: an accept with limb_cnt==MAX_LIMBS-1 and !in_last is forced-treated as last (out_last=1, return to IDLE) and sets err_len. err_len clears only on reset.
- Back-pressure: while out_valid && !out_ready, in_ready=0 and all state holds; out_* must stay stable.
- Single-limb operand (IDLE accept with in_last): out_carry = add_s[32] (add mode).
- Reset mid-operand discards the partial result; the next accepted limb is treated as least-significant.
- add_a/add_b depend only on in_a/in_b, so no combinational path from out_ready into the adder.

Optional Feature:
- Macro MP_ADD_SUB_EN.
- Defined:
  - Adds input port in_sub (1, sampled on the first limb and held for the operand).
  - Subtract mode: add_b = ~in_b and cin0 = 1, computing A-B two's-complement.
  - out_carry=1 means no borrow.
- Undefined: no in_sub port; add only; cin0=0.

Decomposition:
- Package mp_add_pkg: LIMB_W constant, state enum {IDLE, BUSY}, limb-count type.
- One sub-module mp_limb_inc: combinational LIMB_W-bit +c incrementer returning {ovf, sum}.
- The adder stays external, connected through add_a/add_b/add_s.

Test Plan:
- Single limb: A=32'hFFFF_FFFF, B=32'h1, last=1 -> out_sum=0, out_carry=1, out_last=1 after 1 cycle.
- Two limbs with ripple: A={1, FFFFFFFF}, B={0, 1} -> limb0 sum=0, limb1 sum=2, out_carry=0.
- Incrementer carry: A={0, FFFFFFFF, FFFFFFFF}, B={0, 0, 1} (LS first FFFFFFFF/1, then FFFFFFFF/0) -> sums 0, 0, 1, out_carry=0.
- Back-pressure: hold out_ready=0 for 3 cycles mid-operand -> in_ready=0, out_* stable, no limb lost, same final result.
- Overflow: 9 limbs with no last at MAX_LIMBS=8 -> 8th output has out_last=1, err_len=1 sticky; 9th limb starts a new operand.
- MP_ADD_SUB_EN: A=5, B=7, in_sub=1 -> out_sum=32'hFFFF_FFFE, out_carry=0 (borrow).

Source files
------------

// File: rtl/mp_add_pkg.sv
// Shared constants and types for the sequential multi-precision adder.
// Configuration macro: MP_ADD_SUB_EN (subtract mode support).
package mp_add_pkg;

    localparam int ADDER_W       = 32;
    localparam int MAX_LIMBS_DEF = 8;
    localparam int CNT_W_DEF     = $clog2(MAX_LIMBS_DEF) + 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    typedef logic [CNT_W_DEF-1:0] limb_cnt_t;

    function automatic int cnt_w(input int max_limbs);
        return $clog2(max_limbs) + 1;
    endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Limb-pair input stream and result-limb output stream.
// Configuration macro: MP_ADD_SUB_EN adds in_sub.
interface mp_add_seq_if #(
    parameter int LIMB_W = 32
);

    logic              in_valid;
    logic              in_ready;
    logic [LIMB_W-1:0] in_a;
    logic [LIMB_W-1:0] in_b;
    logic              in_last;
`ifdef MP_ADD_SUB_EN
    logic              in_sub;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [LIMB_W-1:0] out_sum;
    logic              out_last;
    logic              out_carry;

    modport master (
`ifdef MP_ADD_SUB_EN
        output in_sub,
`endif
        output in_valid, in_a, in_b, in_last,
        output out_ready,
        input  in_ready,
        input  out_valid, out_sum, out_last, out_carry
    );

    modport slave (
`ifdef MP_ADD_SUB_EN
        input  in_sub,
`endif
        input  in_valid, in_a, in_b, in_last,
        input  out_ready,
        output in_ready,
        output out_valid, out_sum, out_last, out_carry
    );

endinterface

// File: rtl/mp_limb_inc.sv
// Combinational limb incrementer: {ovf, sum} = a + c.
// Configuration macro: none.
module mp_limb_inc #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         c,
    output logic [W-1:0] sum,
    output logic         ovf
);

    // Fold a single carry bit into the limb
    assign {ovf, sum} = {1'b0, a} + {{W{1'b0}}, c};

endmodule

// File: rtl/mp_add_seq.sv
// Sequential multi-precision add controller around an external 32-bit adder.
// Configuration macro: MP_ADD_SUB_EN enables in_sub / A-B mode.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int LIMB_W    = ADDER_W,
    parameter int MAX_LIMBS = MAX_LIMBS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mp_add_seq_if.slave       bus,
    output logic [LIMB_W-1:0] add_a,
    output logic [LIMB_W-1:0] add_b,
    input  logic [LIMB_W:0]   add_s,
    output logic              err_len
);

    localparam int CW = cnt_w(MAX_LIMBS);

    generate
        if (LIMB_W != ADDER_W) begin : g_bad_w
            $error("mp_add_seq: LIMB_W must equal the adder width");
        end
    endgenerate

    state_t          state;
    logic            carry;
    logic [CW-1:0]   limb_cnt;
    logic            sub_cur;
    logic            c;
    logic            acc;
    logic            at_max;
    logic            last_eff;
    logic            carry_next;
    logic            inc_ovf;
    logic [LIMB_W-1:0] inc_sum;

    // Subtract mode is latched on the first limb and held for the operand
`ifdef MP_ADD_SUB_EN
    logic sub_r;
    assign sub_cur = (state == IDLE) ? bus.in_sub : sub_r;
`else
    assign sub_cur = 1'b0;
`endif

    assign add_a = bus.in_a;
    assign add_b = sub_cur ? ~bus.in_b : bus.in_b;

    // First limb takes cin0 (1 for subtract), later limbs the running carry
    assign c = (state == IDLE) ? sub_cur : carry;

    mp_limb_inc #(.W(LIMB_W)) u_inc (
        .a   (add_s[LIMB_W-1:0]),
        .c   (c),
        .sum (inc_sum),
        .ovf (inc_ovf)
    );

    assign carry_next   = add_s[LIMB_W] | inc_ovf;
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign acc          = bus.in_valid && bus.in_ready;
    assign at_max       = (limb_cnt == CW'(MAX_LIMBS - 1));
    assign last_eff     = bus.in_last || at_max;

    // Operand FSM, carry chain and one-entry registered result stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            carry         <= 1'b0;
            limb_cnt      <= '0;
            err_len       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_last  <= 1'b0;
            bus.out_carry <= 1'b0;
`ifdef MP_ADD_SUB_EN
            sub_r         <= 1'b0;
`endif
        end else if (acc) begin
            bus.out_valid <= 1'b1;
            bus.out_sum   <= inc_sum;
            bus.out_last  <= last_eff;
            bus.out_carry <= last_eff ? carry_next : 1'b0;
`ifdef MP_ADD_SUB_EN
            sub_r         <= sub_cur;
`endif
            if (last_eff) begin
                state    <= IDLE;
                carry    <= 1'b0;
                limb_cnt <= '0;
                if (at_max && !bus.in_last) begin
                    err_len <= 1'b1;
                end
            end else begin
                state    <= BUSY;
                carry    <= carry_next;
                limb_cnt <= limb_cnt + 1'b1;
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq with a behavioural 32-bit adder.
// Configuration macro: MP_ADD_SUB_EN adds subtract vectors.
module tb_mp_add_seq;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] sum;
        logic         last;
        logic         carry;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W:0]   add_s;
    logic         err_len;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    mp_add_seq_if #(.LIMB_W(W)) bus();

    mp_add_seq #(.LIMB_W(W), .MAX_LIMBS(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_s   (add_s),
        .err_len (err_len)
    );

    assign add_s = {1'b0, add_a} + {1'b0, add_b};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic last, input logic sub,
                        input logic [W-1:0] es, input logic el,
                        input logic ec);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
`ifdef MP_ADD_SUB_EN
        bus.in_sub   = sub;
`else
        if (sub) $display("note: subtract vector in add-only build");
`endif
        #1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 want 1");
            bus.in_valid = 1'b0;
            return;
        end
        e.sum   = es;
        e.last  = el;
        e.carry = ec;
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Monitor: pop and compare on every output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got sum %h want none",
                             bus.out_sum);
                end else begin
                    e = q.pop_front();
                    check("out_sum", 64'(bus.out_sum), 64'(e.sum));
                    check("out_last", 64'(bus.out_last), 64'(e.last));
                    check("out_carry", 64'(bus.out_carry), 64'(e.carry));
                end
            end
        end
    end

    initial begin
        exp_t e;
        int n;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
`ifdef MP_ADD_SUB_EN
        bus.in_sub    = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_sum", 64'(bus.out_sum), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        check("rst_out_carry", 64'(bus.out_carry), 64'd0);
        check("rst_err_len", 64'(err_len), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;

        // Single limb with carry out
        send(32'hFFFF_FFFF, 32'h1, 1, 0, 32'h0, 1, 1);
        // Two limbs, carry ripples into limb 1
        send(32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 0, 0);
        send(32'h1, 32'h0, 1, 0, 32'h2, 1, 0);
        // Carry absorbed by the incrementer through an all-ones limb
        send(32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 0, 0);
        send(32'hFFFF_FFFF, 32'h0, 0, 0, 32'h0, 0, 0);
        send(32'h0, 32'h0, 1, 0, 32'h1, 1, 0);

        // Back-pressure mid-operand
        send(32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 0, 0);
        send(32'h2, 32'h3, 0, 0, 32'h6, 0, 0);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_a      = 32'hFFFF_FFFF;
        bus.in_b      = 32'hFFFF_FFFF;
        bus.in_last   = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_out_sum", 64'(bus.out_sum), 64'h6);
            check("bp_out_last", 64'(bus.out_last), 64'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        e.sum   = 32'hFFFF_FFFE;
        e.last  = 1'b1;
        e.carry = 1'b1;
        q.push_back(e);
        @(posedge clk);
        idle();

        // Length overflow at MAX_LIMBS=8, ninth limb starts a new operand
        #1;
        check("ovf_err_pre", 64'(err_len), 64'd0);
        for (int i = 1; i <= 8; i++) begin
            send(W'(i), 32'h0, 0, 0, W'(i), (i == 8), 0);
        end
        send(32'h9, 32'h0, 1, 0, 32'h9, 1, 0);
        send(32'hFFFF_FFFF, 32'h1, 1, 0, 32'h0, 1, 1);
        idle();
        #1;
        check("ovf_err_sticky", 64'(err_len), 64'd1);

        // Reset mid-operand drops the partial carry
        send(32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_err", 64'(err_len), 64'd0);
        check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        send(32'h5, 32'h7, 1, 0, 32'hC, 1, 0);

`ifdef MP_ADD_SUB_EN
        send(32'h5, 32'h7, 1, 1, 32'hFFFF_FFFE, 1, 0);
        send(32'h7, 32'h5, 1, 1, 32'h2, 1, 1);
        send(32'h1, 32'h1, 1, 0, 32'h2, 1, 0);
`endif
        idle();

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #3;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
